fp_round_pack: RTL and testbench
================================

FP_ROUND_PACK -- requirements
Module: fp_round_pack

Interface
REQ-001 The block SHALL have these ports, one clock; reset is synchronous and active-high:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  upstream operand valid
- in_ready  out  1  block can accept this cycle
- exp_common  in  8  aligned common exponent from the alignment stage
- val2  in  9  normalizer shift code: [8]=1 decrement / 0 increment, [7:0]=shift amount, [7:0]=8'hFF marks zero mantissa
- mant_norm  in  24  normalizer output: [23]=sign, [22:0]=fraction
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  32  IEEE-754 single {sign, exp[7:0], frac[22:0]}
- zero, ovf, unf  out  1 each  per-result class flags, qualified by out_valid
- clr_flags  in  1  clears sticky flags
- ovf_sticky, unf_sticky  out  1 each  accumulated exception flags

Function
REQ-002 Input transfer SHALL occur on a clk edge where in_valid && in_ready; output transfer where out_valid && out_ready.
REQ-003 Two-stage pipeline (S1 exponent adjust, S2 classify/pack), each stage with its own valid bit.
REQ-004 Latency SHALL be 2 cycles from input transfer to out_valid with no backpressure; throughput 1 per cycle.
REQ-005 S2 SHALL hold when out_valid && !out_ready; S1 SHALL advance only if S2 is empty or transferring.
REQ-006 in_ready SHALL be !S1_valid || S1 advancing this cycle (combinational from out_ready permitted).
REQ-007 Outputs SHALL remain stable while out_valid && !out_ready.
REQ-008 S1: zero marker when val2[7:0]==8'hFF (val2[8] ignored); else e = exp_common + val2[7:0] if val2[8]==0, else exp_common - val2[7:0], computed as 10-bit signed.
REQ-009 S2 priority: zero marker -> {sign,31'b0}, zero=1; else exp_common==8'hFF or e>=255 -> {sign,8'hFF,23'b0}, ovf=1; else e<=0 -> {sign,31'b0}, unf=1 (flush, no subnormals); else {sign,e[7:0],mant_norm[22:0]}.
REQ-010 At most one of zero/ovf/unf SHALL be 1 per result.
REQ-011 Sticky flags SHALL set on the cycle an ovf/unf result is transferred out; clr_flags clears them; simultaneous clr_flags and new event: set wins.
REQ-012 Results SHALL leave in acceptance order; no drop or duplication under any out_ready pattern.

Reset
REQ-013 On rst: both stage valids, out_valid, result, zero, ovf, unf, ovf_sticky, unf_sticky SHALL be 0; in_ready SHALL be 1 in the cycle after rst deasserts.
REQ-014 rst mid-operation SHALL discard in-flight data; no result from before reset SHALL appear afterward.
REQ-015 rst SHALL override in_valid, out_ready and clr_flags in the same cycle.

Structure
REQ-016 Shared package SHALL hold EXP_MAX (8'hFF), ZERO_MARK (8'hFF), widths EXP_W=8, FRAC_W=23, VAL2_W=9.
REQ-017 One sub-module fp_exp_adj (combinational, REQ-008 arithmetic) SHALL be instantiated in S1; the rest stays in fp_round_pack.

Verification
REQ-018 exp=8'h80, val2=9'h001, mant=24'h400000, out_ready=1 -> result 32'h40C00000 two cycles later, all flags 0.
REQ-019 exp=8'h85, val2=9'h103, mant=24'h800000 -> result 32'hC1000000.
REQ-020 val2=9'h0FF, mant=24'h000000 -> result 32'h00000000, zero=1; exp=8'h02, val2=9'h105 -> 32'h00000000, unf=1, unf_sticky=1.
REQ-021 exp=8'hFE, val2=9'h002 -> 32'h7F800000, ovf=1; second ovf transferred on the same cycle as clr_flags -> ovf_sticky stays 1; clr_flags alone -> 0.
REQ-022 out_ready=0, 4 back-to-back inputs -> in_ready falls after 2 accepted; out_ready=1 -> all 4 results in order, none lost.
REQ-023 rst asserted with both stages full -> out_valid=0 next cycle, no stale result after release.

Source files
------------

// File: rtl/fp_round_pack_pkg.sv
// Shared widths, marker constants and the packed-result record for the
// round/pack pipeline.
package fp_round_pack_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int VAL2_W = 9;
  // Signed width wide enough for exp_common +/- 255 without wrap.
  localparam int E_W    = 10;

  localparam logic [EXP_W-1:0] EXP_MAX   = 8'hFF;
  localparam logic [EXP_W-1:0] ZERO_MARK = 8'hFF;

  typedef struct packed {
    logic [31:0] word;
    logic        zero;
    logic        ovf;
    logic        unf;
  } pack_t;

endpackage

// File: rtl/fp_exp_adj.sv
// Combinational exponent adjust: applies the normalizer shift code to the
// common exponent and detects the zero-mantissa marker.
module fp_exp_adj
  import fp_round_pack_pkg::*;
(
  input  logic        [EXP_W-1:0]  exp_common,
  input  logic        [VAL2_W-1:0] val2,
  output logic                     is_zero,
  output logic signed [E_W-1:0]    e
);

  logic signed [E_W-1:0] base;
  logic signed [E_W-1:0] amt;

  assign base    = signed'({2'b00, exp_common});
  assign amt     = signed'({2'b00, val2[EXP_W-1:0]});
  // The direction bit is irrelevant when the shift field carries the marker.
  assign is_zero = (val2[EXP_W-1:0] == ZERO_MARK);
  assign e       = val2[VAL2_W-1] ? (base - amt) : (base + amt);

endmodule

// File: rtl/fp_round_pack.sv
// Two-stage exponent-adjust / classify-pack pipeline producing IEEE-754
// single-precision words with ready/valid handshakes on both sides and
// sticky overflow/underflow flags.
module fp_round_pack
  import fp_round_pack_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EXP_W-1:0]  exp_common,
  input  logic [VAL2_W-1:0] val2,
  input  logic [FRAC_W:0]   mant_norm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       result,
  output logic              zero,
  output logic              ovf,
  output logic              unf,
  input  logic              clr_flags,
  output logic              ovf_sticky,
  output logic              unf_sticky
);

  // Priority: zero marker, then overflow (saturate to infinity), then
  // underflow (flush to signed zero, no subnormals), else normal pack.
  function automatic pack_t classify(
    input logic                  zm,
    input logic                  emax,
    input logic signed [E_W-1:0] e,
    input logic                  sign,
    input logic [FRAC_W-1:0]     frac
  );
    pack_t p;
    p = '0;
    if (zm) begin
      p.word = {sign, 31'b0};
      p.zero = 1'b1;
    end else if (emax || (e >= 10'sd255)) begin
      p.word = {sign, EXP_MAX, {FRAC_W{1'b0}}};
      p.ovf  = 1'b1;
    end else if (e <= 10'sd0) begin
      p.word = {sign, 31'b0};
      p.unf  = 1'b1;
    end else begin
      p.word = {sign, e[EXP_W-1:0], frac};
    end
    return p;
  endfunction

  logic                  in_fire;
  logic                  out_fire;
  logic                  s2_adv;
  logic                  adj_zero;
  logic signed [E_W-1:0] adj_e;

  logic                  vld_p1;
  logic                  zero_p1;
  logic                  emax_p1;
  logic signed [E_W-1:0] e_p1;
  logic                  sign_p1;
  logic [FRAC_W-1:0]     frac_p1;
  pack_t                 pk_p1;

  logic                  vld_p2;
  logic [31:0]           result_p2;
  logic                  zero_p2;
  logic                  ovf_p2;
  logic                  unf_p2;

  assign s2_adv   = !vld_p2 || out_ready;
  assign in_ready = !vld_p1 || s2_adv;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = vld_p2 && out_ready;

  // ---- Stage 1: exponent adjust ----
  fp_exp_adj u_exp_adj (
    .exp_common (exp_common),
    .val2       (val2),
    .is_zero    (adj_zero),
    .e          (adj_e)
  );

  // Capture S1 operands on an accepted input; contents are qualified by vld_p1.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      zero_p1 <= adj_zero;
      emax_p1 <= (exp_common == EXP_MAX);
      e_p1    <= adj_e;
      sign_p1 <= mant_norm[FRAC_W];
      frac_p1 <= mant_norm[FRAC_W-1:0];
    end
  end

  // ---- Stage 2: classify / pack ----
  assign pk_p1 = classify(zero_p1, emax_p1, e_p1, sign_p1, frac_p1);

  // Stage valids, registered result/flags and sticky exception accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      result_p2  <= '0;
      zero_p2    <= 1'b0;
      ovf_p2     <= 1'b0;
      unf_p2     <= 1'b0;
      ovf_sticky <= 1'b0;
      unf_sticky <= 1'b0;
    end else begin
      if (in_ready) begin
        vld_p1 <= in_valid;
      end
      if (s2_adv) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          result_p2 <= pk_p1.word;
          zero_p2   <= pk_p1.zero;
          ovf_p2    <= pk_p1.ovf;
          unf_p2    <= pk_p1.unf;
        end
      end
      // A new event on the same cycle as clr_flags keeps the flag set.
      ovf_sticky <= (ovf_sticky && !clr_flags) || (out_fire && ovf_p2);
      unf_sticky <= (unf_sticky && !clr_flags) || (out_fire && unf_p2);
    end
  end

  assign out_valid = vld_p2;
  assign result    = result_p2;
  assign zero      = zero_p2;
  assign ovf       = ovf_p2;
  assign unf       = unf_p2;

endmodule

// File: tb/tb_fp_round_pack.sv
// Self-checking bench for fp_round_pack: directed scenarios followed by
// randomized traffic with random backpressure, checked against a queue-based
// reference model built from the IEEE packing rules.
module tb_fp_round_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  exp_common;
  logic [8:0]  val2;
  logic [23:0] mant_norm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero, ovf, unf;
  logic        clr_flags;
  logic        ovf_sticky, unf_sticky;

  fp_round_pack dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .exp_common (exp_common),
    .val2       (val2),
    .mant_norm  (mant_norm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .ovf        (ovf),
    .unf        (unf),
    .clr_flags  (clr_flags),
    .ovf_sticky (ovf_sticky),
    .unf_sticky (unf_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic        z;
    logic        o;
    logic        u;
  } exp_t;

  int          total = 0;
  int          bad   = 0;
  exp_t        q[$];
  logic        m_ovf_st   = 1'b0;
  logic        m_unf_st   = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_res   = '0;

  function automatic exp_t model(input logic [7:0] ex, input logic [8:0] v, input logic [23:0] m);
    exp_t r;
    int   e;
    r.word = '0; r.z = 1'b0; r.o = 1'b0; r.u = 1'b0;
    if (v[7:0] == 8'hFF) begin
      r.word = {m[23], 31'b0};
      r.z    = 1'b1;
    end else begin
      e = v[8] ? (int'(ex) - int'(v[7:0])) : (int'(ex) + int'(v[7:0]));
      if (ex == 8'hFF || e >= 255) begin
        r.word = {m[23], 8'hFF, 23'b0};
        r.o    = 1'b1;
      end else if (e <= 0) begin
        r.word = {m[23], 31'b0};
        r.u    = 1'b1;
      end else begin
        r.word = {m[23], 8'(e), m[22:0]};
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: settle, check holds/stickies, score transfers at the coming
  // edge, then advance to the next falling edge.
  task automatic tick(output bit in_fire);
    exp_t x;
    bit   of;
    logic eo, eu;
    eo = 1'b0; eu = 1'b0;
    #1;
    check("ovf_sticky", 32'(ovf_sticky), 32'(m_ovf_st));
    check("unf_sticky", 32'(unf_sticky), 32'(m_unf_st));
    if (prev_stall) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_hold", result, prev_res);
    end
    in_fire = !rst && in_valid && in_ready;
    of      = !rst && out_valid && out_ready;
    if (rst) begin
      q.delete();
      m_ovf_st   = 1'b0;
      m_unf_st   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (of) begin
        if (q.size() == 0) begin
          check("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          x = q.pop_front();
          check("result", result, x.word);
          check("zero", 32'(zero), 32'(x.z));
          check("ovf", 32'(ovf), 32'(x.o));
          check("unf", 32'(unf), 32'(x.u));
          eo = x.o;
          eu = x.u;
        end
      end
      m_ovf_st = (m_ovf_st && !clr_flags) || eo;
      m_unf_st = (m_unf_st && !clr_flags) || eu;
      if (in_fire) q.push_back(model(exp_common, val2, mant_norm));
      prev_stall = out_valid && !out_ready;
      prev_res   = result;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic [7:0] ex, input logic [8:0] v, input logic [23:0] m);
    exp_common = ex;
    val2       = v;
    mant_norm  = m;
  endtask

  // Single transaction with out_ready=1, checking the 2-cycle latency and the
  // hand-computed expected word/flags in addition to the model.
  task automatic directed(input string tag, input logic [7:0] ex, input logic [8:0] v,
                          input logic [23:0] m, input logic [31:0] w,
                          input logic z, input logic o, input logic u);
    bit f;
    out_ready = 1'b1;
    drive(ex, v, m);
    in_valid = 1'b1;
    tick(f);
    check({tag, "_accept"}, 32'(f), 32'd1);
    in_valid = 1'b0;
    check({tag, "_lat1"}, 32'(out_valid), 32'd0);
    tick(f);
    check({tag, "_lat2"}, 32'(out_valid), 32'd1);
    check({tag, "_word"}, result, w);
    check({tag, "_zero"}, 32'(zero), 32'(z));
    check({tag, "_ovf"}, 32'(ovf), 32'(o));
    check({tag, "_unf"}, 32'(unf), 32'(u));
    tick(f);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          f;
    int          acc;
    int          idx;
    logic [7:0]  ex8;
    logic [7:0]  amt;
    logic [7:0]  ex_a [4];
    logic [8:0]  v_a  [4];
    logic [23:0] m_a  [4];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_flags = 1'b0;
    exp_common = '0; val2 = '0; mant_norm = '0;
    @(negedge clk);
    tick(f);
    // rst must override a simultaneous in_valid/out_ready/clr_flags.
    drive(8'h80, 9'h001, 24'h400000);
    in_valid = 1'b1; out_ready = 1'b1; clr_flags = 1'b1;
    tick(f);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", {29'd0, zero, ovf, unf}, 32'd0);
    check("rst_sticky", {30'd0, ovf_sticky, unf_sticky}, 32'd0);
    in_valid = 1'b0; clr_flags = 1'b0; rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    tick(f);
    check("post_rst_empty1", 32'(out_valid), 32'd0);
    tick(f);
    check("post_rst_empty2", 32'(out_valid), 32'd0);

    directed("inc1",  8'h80, 9'h001, 24'h400000, 32'h40C00000, 1'b0, 1'b0, 1'b0);
    directed("dec3",  8'h85, 9'h103, 24'h800000, 32'hC1000000, 1'b0, 1'b0, 1'b0);
    directed("zmark", 8'h40, 9'h0FF, 24'h000000, 32'h00000000, 1'b1, 1'b0, 1'b0);
    directed("zmarkd", 8'h40, 9'h1FF, 24'hABCDEF, 32'h80000000, 1'b1, 1'b0, 1'b0);
    directed("unf",   8'h02, 9'h105, 24'h000000, 32'h00000000, 1'b0, 1'b0, 1'b1);
    check("unf_sticky_set", 32'(unf_sticky), 32'd1);
    directed("edge1", 8'h01, 9'h100, 24'h123456, 32'h00923456, 1'b0, 1'b0, 1'b0);
    directed("edge254", 8'hFD, 9'h001, 24'h000001, 32'h7F000001, 1'b0, 1'b0, 1'b0);
    directed("emax",  8'hFF, 9'h105, 24'h800000, 32'hFF800000, 1'b0, 1'b1, 1'b0);
    directed("ovf",   8'hFE, 9'h002, 24'h000000, 32'h7F800000, 1'b0, 1'b1, 1'b0);
    check("ovf_sticky_set", 32'(ovf_sticky), 32'd1);

    // Second overflow leaves on the same cycle as clr_flags: set wins.
    out_ready = 1'b0;
    drive(8'hFE, 9'h002, 24'h000000);
    in_valid = 1'b1;
    tick(f);
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) tick(f);
    check("wait_ovf2", 32'(out_valid), 32'd1);
    clr_flags = 1'b1; out_ready = 1'b1;
    tick(f);
    clr_flags = 1'b0;
    check("clr_vs_set", 32'(ovf_sticky), 32'd1);
    clr_flags = 1'b1;
    tick(f);
    clr_flags = 1'b0;
    check("clr_ovf", 32'(ovf_sticky), 32'd0);
    check("clr_unf", 32'(unf_sticky), 32'd0);

    // Backpressure: four back-to-back inputs with the output blocked.
    for (int i = 0; i < 4; i++) begin
      ex_a[i] = 8'($urandom_range(20, 200));
      v_a[i]  = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 15))};
      m_a[i]  = 24'($urandom);
    end
    out_ready = 1'b0; idx = 0; acc = 0;
    for (int i = 0; i < 4; i++) begin
      drive(ex_a[idx], v_a[idx], m_a[idx]);
      in_valid = 1'b1;
      tick(f);
      if (f) begin acc++; idx++; end
    end
    check("bp_accepted", 32'(acc), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 40 && idx < 4; i++) begin
      drive(ex_a[idx], v_a[idx], m_a[idx]);
      in_valid = 1'b1;
      tick(f);
      if (f) idx++;
    end
    check("bp_all_accepted", 32'(idx), 32'd4);
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick(f);
    check("bp_drained", 32'(q.size()), 32'd0);

    // Reset with both stages full must discard everything.
    out_ready = 1'b0;
    drive(8'h90, 9'h002, 24'h111111);
    in_valid = 1'b1;
    tick(f);
    drive(8'h91, 9'h103, 24'h222222);
    tick(f);
    in_valid = 1'b0;
    check("full_before_rst", 32'(out_valid), 32'd1);
    check("full_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    tick(f);
    rst = 1'b0;
    check("rst_flush_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) acc++;
      tick(f);
    end
    check("no_stale_after_rst", 32'(acc), 32'd0);

    // Randomized traffic with random backpressure and flag clears.
    for (int i = 0; i < 600; i++) begin
      ex8 = 8'($urandom);
      if ($urandom_range(0, 15) == 0) amt = 8'hFF;
      else if ($urandom_range(0, 3) == 0) amt = 8'($urandom);
      else amt = 8'($urandom_range(0, 40));
      drive(ex8, {1'($urandom_range(0, 1)), amt}, 24'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clr_flags = ($urandom_range(0, 15) == 0);
      tick(f);
    end
    in_valid = 1'b0; out_ready = 1'b1; clr_flags = 1'b0;
    for (int i = 0; i < 10; i++) tick(f);
    check("rand_drained", 32'(q.size()), 32'd0);
    check("rand_idle", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
